// File: rtl/motor_mode_controller.sv
// motor_mode_controller
//   Speed-mode FSM (STOP/LOW/MID/HIGH), seconds-resolution auto-off countdown
//   timer and glitch-free PWM drive for a fan/motor. It is driven by debounced
//   single-cycle button pulses.
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_btn_speed    pulse: advance speed mode (STOP->LOW->MID->HIGH->LOW)
//   i_btn_timer    pulse: advance auto-off setting (ignored in STOP)
//   i_btn_stop     pulse: force STOP and clear the timer
//   o_pwm          registered PWM motor drive
//   o_speed        current mode: 0 STOP, 1 LOW, 2 MID, 3 HIGH
//   o_timer_sec    remaining auto-off seconds, 0 when inactive
//   o_timer_active countdown running
//   o_running      mode != STOP
module motor_mode_controller #(
   parameter int unsigned TICK_DIV        = 100_000_000,
   parameter int unsigned PWM_PERIOD      = 100,
   parameter int unsigned DUTY_LOW        = 25,
   parameter int unsigned DUTY_MID        = 50,
   parameter int unsigned DUTY_HIGH       = 90,
   parameter int unsigned TIMER_STEP      = 60,
   parameter int unsigned TIMER_MAX_STEPS = 3
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_btn_speed,
   input  logic        i_btn_timer,
   input  logic        i_btn_stop,
   output logic        o_pwm,
   output logic [1:0]  o_speed,
   output logic [15:0] o_timer_sec,
   output logic        o_timer_active,
   output logic        o_running
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // One extra bit so a duty equal to PWM_PERIOD is representable.
   localparam int unsigned PwmW  = $clog2(PWM_PERIOD + 1);
   localparam int unsigned StepW = (TIMER_MAX_STEPS > 0) ? $clog2(TIMER_MAX_STEPS + 1) : 1;

   localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
   localparam logic [PwmW-1:0]  PwmLast  = PwmW'(PWM_PERIOD - 1);
   localparam logic [StepW-1:0] StepMax  = StepW'(TIMER_MAX_STEPS);
   localparam logic [PwmW-1:0]  DutyLow  = PwmW'(DUTY_LOW);
   localparam logic [PwmW-1:0]  DutyMid  = PwmW'(DUTY_MID);
   localparam logic [PwmW-1:0]  DutyHigh = PwmW'(DUTY_HIGH);

   typedef enum logic [1:0] {
      StStop = 2'd0,
      StLow  = 2'd1,
      StMid  = 2'd2,
      StHigh = 2'd3
   } mode_e;

   mode_e            mode_q, mode_d;
   logic [StepW-1:0] step_q, step_d, step_nx;
   logic [15:0]      timer_q, timer_d;
   logic             active_q, active_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic [PwmW-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [PwmW-1:0]  duty_q, duty_d, mode_duty;
   logic             pwm_q, pwm_d;
   logic             tick, expire;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         mode_q     <= StStop;
         step_q     <= '0;
         timer_q    <= '0;
         active_q   <= 1'b0;
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
         pwm_q      <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         step_q     <= step_d;
         timer_q    <= timer_d;
         active_q   <= active_d;
         tick_cnt_q <= tick_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
         pwm_q      <= pwm_d;
      end
   end

   assign tick    = active_q && (tick_cnt_q == TickLast);
   assign expire  = tick && (timer_q == 16'd1);
   assign step_nx = (step_q == StepMax) ? '0 : step_q + StepW'(1);

   // Mode / timer next state. Event priority: stop > expiry > speed > timer.
   always_comb begin
      mode_d     = mode_q;
      step_d     = step_q;
      timer_d    = timer_q;
      active_d   = active_q;
      tick_cnt_d = '0;

      if (active_q) begin
         tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
      end
      if (tick) begin
         timer_d = timer_q - 16'd1;
      end

      if (i_btn_stop || expire) begin
         mode_d     = StStop;
         step_d     = '0;
         timer_d    = '0;
         active_d   = 1'b0;
         tick_cnt_d = '0;
      end else if (i_btn_speed) begin
         // Speed changes leave the running countdown untouched.
         unique case (mode_q)
            StStop:  mode_d = StLow;
            StLow:   mode_d = StMid;
            StMid:   mode_d = StHigh;
            StHigh:  mode_d = StLow;
            default: mode_d = StStop;
         endcase
      end else if (i_btn_timer && (mode_q != StStop)) begin
         // Reload from the selected step, not the remaining time.
         step_d     = step_nx;
         timer_d    = 16'(step_nx * TIMER_STEP);
         active_d   = (step_nx != '0);
         tick_cnt_d = '0;
      end
   end

   // PWM: duty only changes at the period boundary, so no runt pulses.
   always_comb begin
      mode_duty = '0;
      unique case (mode_q)
         StLow:   mode_duty = DutyLow;
         StMid:   mode_duty = DutyMid;
         StHigh:  mode_duty = DutyHigh;
         default: mode_duty = '0;
      endcase

      duty_d    = duty_q;
      pwm_cnt_d = pwm_cnt_q + PwmW'(1);
      if (pwm_cnt_q == PwmLast) begin
         pwm_cnt_d = '0;
         duty_d    = mode_duty;
      end
      pwm_d = (pwm_cnt_q < duty_q);
   end

   assign o_pwm          = pwm_q;
   assign o_speed        = mode_q;
   assign o_timer_sec    = timer_q;
   assign o_timer_active = active_q;
   assign o_running      = (mode_q != StStop);

endmodule
